// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment scanner:
// scan state encodings, active-low segment patterns and anode patterns.
package seg7_pkg;

    // Scan states, visited in order SHOW0 -> GAP0 -> SHOW1 -> GAP1
    localparam logic [1:0] SHOW0 = 2'd0;
    localparam logic [1:0] GAP0  = 2'd1;
    localparam logic [1:0] SHOW1 = 2'd2;
    localparam logic [1:0] GAP1  = 2'd3;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_DIGITS [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Anode patterns, active-low: an[1] tens, an[0] units
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_OFF   = 2'b11;

    // Two BCD-ish digits as captured from the upstream counter
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } digits_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern.
// Values above 9 show a dash (segment g only).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Table lookup for 0..9, dash for everything else
    always_comb begin
        seg = SEG_DASH;
        if (value <= 4'd9) begin
            seg = SEG_DIGITS[value];
        end
    end

endmodule

// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed seven-segment driver with dead time between digits.
// Digits are captured into a shadow register on load and copied into the
// display register once per frame, so a frame never shows a torn value.
module seg7_scan_2digit
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int MAX_CNT = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] presc;
    logic             terminal;
    logic             commit;

    digits_t          shadow;
    digits_t          disp;
    digits_t          disp_eff;

    logic [3:0]       dec_in;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_nx;
    logic [1:0]       an_nx;

    // Terminal count depends on whether we are lighting a digit or in dead time
    always_comb begin
        terminal = (state == SHOW0 || state == SHOW1) ? (presc == SHOW_LAST)
                                                      : (presc == GAP_LAST);
        case (state)
            SHOW0:   state_nx = GAP0;
            GAP0:    state_nx = SHOW1;
            SHOW1:   state_nx = GAP1;
            default: state_nx = SHOW0;
        endcase
    end

    // The first SHOW0 cycle (including the one right after reset) is the commit point
    assign commit   = (state == SHOW0) && (presc == '0);
    // During the commit cycle the display already carries the freshly committed digits
    assign disp_eff = commit ? shadow : disp;
    assign dec_in   = (state == SHOW1) ? disp_eff.tens : disp_eff.units;

    seg7_decode u_decode (
        .value (dec_in),
        .seg   (dec_seg)
    );

    // Scan state and prescaler
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SHOW0;
            presc <= '0;
        end else if (terminal) begin
            state <= state_nx;
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Shadow capture on load; a commit in the same cycle sees the old value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= '{tens: dig1, units: dig0};
        end
    end

    // Frame commit: display register follows the shadow once per frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp <= '0;
        end else if (commit) begin
            disp <= shadow;
        end
    end

    // Per-state drive; a leading-zero tens digit is dark but keeps its time slot
    always_comb begin
        an_nx  = AN_OFF;
        seg_nx = SEG_BLANK;
        case (state)
            SHOW0: begin
                an_nx  = AN_UNITS;
                seg_nx = dec_seg;
            end
            SHOW1: begin
                if (!(blank_lz && disp_eff.tens == 4'd0)) begin
                    an_nx  = AN_TENS;
                    seg_nx = dec_seg;
                end
            end
            default: begin
                an_nx  = AN_OFF;
                seg_nx = SEG_BLANK;
            end
        endcase
    end

    // Registered outputs; reset forces everything dark immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nx;
            an         <= an_nx;
            frame_tick <= commit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Directed bench for seg7_scan_2digit with REFRESH_DIV=4, GAP_CYCLES=2.
// Expected per-cycle outputs are pushed to a queue one frame at a time and
// popped as the DUT produces each registered output.
module tb_seg7_scan_2digit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dig1 = 4'd0;
    logic [3:0] dig0 = 4'd0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    seg7_scan_2digit #(.REFRESH_DIV(4), .GAP_CYCLES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .dig1       (dig1),
        .dig0       (dig0),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Push the expected outputs for the first n cycles of one 12-cycle frame
    task automatic push_frame(input logic [6:0] su, input logic [6:0] st,
                              input bit tens_on, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i < 4) begin
                e.an = 2'b10; e.seg = su;
            end else if (i >= 6 && i < 10 && tens_on) begin
                e.an = 2'b01; e.seg = st;
            end else begin
                e.an = 2'b11; e.seg = 7'h7F;
            end
            e.ft = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    // Run n cycles of a frame, optionally pulsing load at cycle load_at
    task automatic run_frame(input string name, input logic [6:0] su, input logic [6:0] st,
                             input bit tens_on, input int n, input int load_at,
                             input logic [3:0] d1, input logic [3:0] d0, input logic blz);
        exp_t e;
        push_frame(su, st, tens_on, n);
        for (int i = 0; i < n; i++) begin
            blank_lz = blz;
            load = (i == load_at);
            if (i == load_at) begin
                dig1 = d1;
                dig0 = d0;
            end
            @(posedge clock);
            #1;
            load = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s c%0d queue observed=empty expected=entry", name, i);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s c%0d an", name, i), {5'd0, an}, {5'd0, e.an});
                chk($sformatf("%s c%0d seg", name, i), seg, e.seg);
                chk($sformatf("%s c%0d tick", name, i), {6'd0, frame_tick}, {6'd0, e.ft});
            end
        end
    endtask

    initial begin
        // Held in reset: everything dark
        repeat (2) @(posedge clock);
        #1;
        chk("reset an", {5'd0, an}, 7'h03);
        chk("reset seg", seg, 7'h7F);
        chk("reset tick", {6'd0, frame_tick}, 7'd0);
        reset = 1'b0;

        // Frame 1: zeros after reset; load 4,2 mid-frame
        run_frame("f1", 7'h40, 7'h40, 1'b1, 12, 5, 4'd4, 4'd2, 1'b0);
        // Frame 2: shows 42; load 0,7 for the next frame
        run_frame("f2", 7'h24, 7'h19, 1'b1, 12, 3, 4'd0, 4'd7, 1'b1);
        // Frame 3: 07 with leading-zero blanking
        run_frame("f3", 7'h78, 7'h40, 1'b0, 12, -1, 4'd0, 4'd0, 1'b1);
        // Frame 4: 07 without blanking; load C,A
        run_frame("f4", 7'h78, 7'h40, 1'b1, 12, 7, 4'hC, 4'hA, 1'b0);
        // Frame 5: dashes; load 1,3 in the commit cycle itself
        run_frame("f5", 7'h3F, 7'h3F, 1'b1, 12, 0, 4'd1, 4'd3, 1'b0);
        // Frame 6: shows 13, interrupted by reset during the tens digit
        run_frame("f6", 7'h30, 7'h79, 1'b1, 8, -1, 4'd0, 4'd0, 1'b0);
        chk("pre-reset an", {5'd0, an}, 7'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset an", {5'd0, an}, 7'h03);
        chk("async reset seg", seg, 7'h7F);
        chk("async reset tick", {6'd0, frame_tick}, 7'd0);
        @(posedge clock);
        #1;
        chk("held reset an", {5'd0, an}, 7'h03);
        reset = 1'b0;

        // Frame 7: restart from zeros
        run_frame("f7", 7'h40, 7'h40, 1'b1, 12, -1, 4'd0, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
